m_spi_control: RTL and testbench
================================

Name: m_spi_control

Overview:
- SPI mode-0 master that drives the SCLK/MOSI/SS/MISO pins of the `s_spi_control` slave.
- Converts a single-cycle start request plus a parallel word into one SS-framed, MSB-first transfer.
- Returns the word shifted in on MISO.
- Sits between the system-clocked controller logic and the SPI pins. It is the upstream feeder of the slave.

Parameters:
- DATA_LENGTH, 8, bits per frame; must be ≥2.
- CLK_DIV, 4, clk cycles per SCLK half-period (T); must be ≥2.

Ports:
- clk  input  1  system clock; one clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  DATA_LENGTH  word to send; captured on the accepting edge.
- rx_data  output  DATA_LENGTH  last received word; held until the next frame completes.
- busy  output  1  high from the accepting edge until the return to IDLE.
- done  output  1  one-cycle pulse when rx_data updates.
- SCLK  output  1  SPI clock; idles low.
- MOSI  output  1  serial data to slave.
- SS  output  1  active-low slave select; idles high.
- MISO  input  1  serial data from slave; may be Z while SS is high and is ignored then.

Behaviour:
- Reset (async, rst_n=0) forces outputs immediately: SS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0. State goes to IDLE and all counters to 0.
- Reset mid-frame aborts the frame at once. The slave sees SS rise and latches a partial word; this is accepted behaviour.
- All pin outputs are registered. MOSI, SCLK and SS are glitch-free.
- States: IDLE, SETUP, XFER, HOLD, GAP. A half-period counter counts 0..T-1; a bit counter counts 0..DATA_LENGTH-1.
- Let E0 be the edge where start=1 is sampled in IDLE.
- IDLE→SETUP at E0:
  - tx shift register ← tx_data.
  - SS←0, busy←1, MOSI←tx_data[DATA_LENGTH-1], SCLK stays 0.
- SETUP lasts T cycles, then →XFER.
- XFER runs DATA_LENGTH SCLK periods, each T cycles high then T cycles low.
  - Rising edge i (i=1..DATA_LENGTH) at E0+(2i-1)T. On that clk edge, MISO is shifted into the rx shift register LSB-first-in, so the MSB ends in bit DATA_LENGTH-1.
  - Falling edge i at E0+2iT. On that clk edge MOSI ← next bit (MSB→LSB), except after the last bit, where MOSI holds.
- After falling edge DATA_LENGTH: →HOLD for T cycles, SCLK stays 0, SS stays 0.
- At E0+(2·DATA_LENGTH+1)T:
  - SS←1, rx_data←rx shift register, done←1 for exactly one cycle. →GAP.
  - Ordering guarantees the slave sees its last SCLK rise before SS rises.
- GAP lasts T cycles with SS high. At E0+(2·DATA_LENGTH+2)T: busy←0, →IDLE, MOSI←0.
- Defaults (DATA_LENGTH=8, T=4): SS falls at E0; first SCLK rise at E0+4; SS rises and done pulses at E0+68; busy falls at E0+72.
- start while busy=1 is ignored, with no queueing.
- start held high continuously: the next frame is accepted on the first IDLE cycle, giving back-to-back frames separated by the T-cycle GAP.
- tx_data changes after E0 do not affect the frame in flight.
- SCLK period is 2T. Duty cycle is exactly 50%.

Test Plan:
- Loopback (MISO tied to MOSI), tx_data=0xA5, start pulse → MOSI serial 1,0,1,0,0,1,0,1; rx_data=0xA5; done high exactly one cycle at E0+68; busy low at E0+72.
- Against s_spi_control with o_data=0x3C, two frames sending 0x81 then 0x7E:
  - Frame 1: slave i_data=0x81 after frame 1 SS rise.
  - Frame 2: master rx_data=0x3C after frame 2 (slave reloads MISO data on SS rise); slave i_data=0x7E.
- Edge count: any frame → exactly 8 SCLK rising edges while SS=0; SCLK=0 on both SS edges; no SCLK toggles while SS=1.
- start pulsed at E0+10 during a frame → ignored; only one done pulse; busy continuous.
- rst_n low at E0+30 → SS=1, SCLK=0, busy=0, rx_data=0 asynchronously (before next clk edge). After release, a new frame with tx_data=0xFF completes with correct timing.
- CLK_DIV=2, DATA_LENGTH=16, start held high → back-to-back frames with SS high exactly 2 cycles between frames; done pulses every 68 cycles.

Source files
------------

// File: rtl/m_spi_control.sv
// -----------------------------------------------------------------------------
// m_spi_control
// SPI mode-0 master. A single-cycle start request with a parallel word produces
// one SS-framed, MSB-first transfer. The word shifted in on MISO is returned on
// rx_data, and done pulses for one cycle when rx_data updates.
//
// Frame timeline (T = CLK_DIV, E0 = the edge that accepts start):
//   E0                 SS falls, MOSI = MSB
//   E0+(2i-1)T         SCLK rise i, MISO sampled
//   E0+2iT             SCLK fall i, MOSI advances (holds after the last bit)
//   E0+(2N+1)T         SS rises, rx_data updated, done pulses
//   E0+(2N+2)T         busy falls (or the next frame starts if start is high)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    transfer request, sampled only when idle
//   tx_data  word to send, captured on the accepting edge
//   rx_data  last received word
//   busy     high for the whole frame, including the trailing gap
//   done     one-cycle pulse when rx_data updates
//   SCLK     SPI clock, idles low
//   MOSI     serial data out
//   SS       active-low slave select, idles high
//   MISO     serial data in, ignored while SS is high
// -----------------------------------------------------------------------------
module m_spi_control #(
   parameter int DATA_LENGTH = 8,
   parameter int CLK_DIV     = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [DATA_LENGTH-1:0] tx_data,
   output logic [DATA_LENGTH-1:0] rx_data,
   output logic                   busy,
   output logic                   done,
   output logic                   SCLK,
   output logic                   MOSI,
   output logic                   SS,
   input  logic                   MISO
);

   localparam int HW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_LENGTH);
   localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_LENGTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [HW-1:0]          half_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_LENGTH-1:0] tx_sr;
   logic [DATA_LENGTH-1:0] rx_sr;

   logic tick;
   logic last_bit;
   logic accept;
   logic sclk_rise;
   logic sclk_fall;

   assign tick     = (half_cnt == H_LAST);
   assign last_bit = (bit_cnt == B_LAST);
   // The last gap edge doubles as an idle sample so a held start gives
   // back-to-back frames separated only by the T-cycle gap.
   assign accept    = start && ((state == IDLE) || (state == GAP && tick));
   assign sclk_rise = tick && ((state == SETUP) || (state == XFER && !SCLK));
   assign sclk_fall = tick && (state == XFER) && SCLK;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   if (tick) state_nxt = XFER;
         XFER:    if (sclk_fall && last_bit) state_nxt = HOLD;
         HOLD:    if (tick) state_nxt = GAP;
         GAP:     if (tick) state_nxt = start ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         half_cnt <= '0;
         bit_cnt  <= '0;
         SCLK     <= 1'b0;
         SS       <= 1'b1;
         MOSI     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;

         if (state == IDLE || tick)
            half_cnt <= '0;
         else
            half_cnt <= half_cnt + HW'(1);

         if (accept) begin
            SS      <= 1'b0;
            busy    <= 1'b1;
            MOSI    <= tx_data[DATA_LENGTH-1];
            bit_cnt <= '0;
         end

         if (sclk_rise)
            SCLK <= 1'b1;

         if (sclk_fall) begin
            SCLK <= 1'b0;
            // MOSI holds its last bit through HOLD so the slave never sees a
            // data change close to SS rising.
            if (!last_bit) begin
               bit_cnt <= bit_cnt + BW'(1);
               MOSI    <= tx_sr[DATA_LENGTH-2];
            end
         end

         // SS rises a full half-period after the last falling edge, so the
         // slave has already seen its final SCLK rise.
         if (state == HOLD && tick) begin
            SS      <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sr;
         end

         if (state == GAP && tick && !start) begin
            busy <= 1'b0;
            MOSI <= 1'b0;
         end
      end
   end

   // Shift registers carry only data; every bit is rewritten within a
   // complete frame before it is observed.
   always_ff @(posedge clk) begin
      if (accept)
         tx_sr <= tx_data;
      else if (sclk_fall)
         tx_sr <= {tx_sr[DATA_LENGTH-2:0], 1'b0};

      if (sclk_rise)
         rx_sr <= {rx_sr[DATA_LENGTH-2:0], MISO};
   end

endmodule

// File: tb/tb_m_spi_control.sv
// -----------------------------------------------------------------------------
// tb_m_spi_control
// Two masters: dut_a (8-bit, T=4) for loopback, slave-model, abort and
// ignored-start frames; dut_b (16-bit, T=2) for back-to-back frames with start
// held high. Expected rx words and done cycles are queued when a frame is
// issued and popped by a monitor when done is seen.
// -----------------------------------------------------------------------------
module tb_m_spi_control;

   typedef struct {
      logic [7:0] d;
      int         t;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- DUT A ----------------
   logic       rst_n_a = 1'b0;
   logic       start_a = 1'b0;
   logic [7:0] tx_a    = 8'h00;
   logic [7:0] rx_a;
   logic       busy_a, done_a, sclk_a, mosi_a, ss_a, miso_a;
   logic       use_slv = 1'b0;
   logic       slv_miso;

   assign miso_a = use_slv ? slv_miso : mosi_a;

   m_spi_control #(.DATA_LENGTH(8), .CLK_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .tx_data(tx_a),
      .rx_data(rx_a), .busy(busy_a), .done(done_a),
      .SCLK(sclk_a), .MOSI(mosi_a), .SS(ss_a), .MISO(miso_a)
   );

   // ---------------- DUT B ----------------
   logic        rst_n_b = 1'b0;
   logic        start_b = 1'b0;
   logic [15:0] tx_b    = 16'hC3A5;
   logic [15:0] rx_b;
   logic        busy_b, done_b, sclk_b, mosi_b, ss_b;

   m_spi_control #(.DATA_LENGTH(16), .CLK_DIV(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .tx_data(tx_b),
      .rx_data(rx_b), .busy(busy_b), .done(done_b),
      .SCLK(sclk_b), .MOSI(mosi_b), .SS(ss_b), .MISO(mosi_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural slave (mode 0, reloads o_data on SS rise) ----
   logic [7:0] s_out   = 8'h3C;
   logic [7:0] s_in    = 8'h00;
   logic [7:0] s_idata = 8'h00;
   assign slv_miso = s_out[7];

   always @(posedge ss_a) begin
      s_idata = s_in;
      s_out   = 8'h3C;
   end
   always @(posedge sclk_a) if (!ss_a) s_in = {s_in[6:0], mosi_a};
   always @(negedge sclk_a) if (!ss_a) s_out = {s_out[6:0], 1'b0};

   // ---------------- scoreboard monitor A ----------------
   exp_t qa[$];
   int   ndone_a = 0;

   always @(negedge clk) begin
      if (rst_n_a && done_a) begin
         ndone_a++;
         if (qa.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_a: unexpected done rx=0x%0h at cycle %0d", rx_a, cyc);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("rx_a", {24'h0, rx_a}, {24'h0, e.d});
            chk("done_cycle_a", cyc, e.t);
         end
      end
   end

   // ---------------- pin monitor A ----------------
   int         rise_cnt = 0;
   logic [7:0] mosi_cap = 8'h00;

   always @(posedge sclk_a) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[6:0], mosi_a};
   end

   always @(negedge ss_a) begin
      rise_cnt = 0;
      chk("sclk_at_ss_fall", {31'h0, sclk_a}, 32'h0);
   end

   always @(posedge ss_a) begin
      if (rst_n_a) begin
         chk("sclk_rises_per_frame", rise_cnt, 8);
         chk("sclk_at_ss_rise", {31'h0, sclk_a}, 32'h0);
      end
   end

   always @(sclk_a) begin
      if (rst_n_a && ss_a) begin
         n_cmp++;
         n_err++;
         $display("FAIL sclk_idle: SCLK toggled to %0b while SS=1 at cycle %0d", sclk_a, cyc);
      end
   end

   // ---------------- monitor B ----------------
   int   ndone_b     = 0;
   int   last_done_b = -1;
   int   ss_rise_b   = -1;
   logic ss_prev_b   = 1'b1;

   always @(negedge clk) begin
      if (rst_n_b) begin
         if (done_b) begin
            ndone_b++;
            chk("rx_b", {16'h0, rx_b}, 32'h0000C3A5);
            if (last_done_b >= 0) chk("done_period_b", cyc - last_done_b, 68);
            last_done_b = cyc;
         end
         if (ss_b && !ss_prev_b) ss_rise_b = cyc;
         if (!ss_b && ss_prev_b && ss_rise_b >= 0) chk("ss_gap_b", cyc - ss_rise_b, 2);
         ss_prev_b = ss_b;
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_frame(input logic [7:0] tx, input logic [7:0] exp_rx,
                              input bit push, output int e0);
      exp_t e;
      @(negedge clk);
      tx_a    = tx;
      start_a = 1'b1;
      @(negedge clk);
      e0      = cyc;
      start_a = 1'b0;
      tx_a    = ~tx;   // late changes must not reach the frame in flight
      if (push) begin
         e.d = exp_rx;
         e.t = e0 + 68;
         qa.push_back(e);
      end
   endtask

   task automatic wait_end(input int e0, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy_a) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: busy never fell (cycle %0d)", nm, cyc);
      end else begin
         chk(nm, cyc - e0, 72);
      end
   endtask

   initial begin
      int e0;
      int d0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ss",   {31'h0, ss_a},   32'h1);
      chk("rst_sclk", {31'h0, sclk_a}, 32'h0);
      chk("rst_mosi", {31'h0, mosi_a}, 32'h0);
      chk("rst_busy", {31'h0, busy_a}, 32'h0);
      chk("rst_done", {31'h0, done_a}, 32'h0);
      chk("rst_rx",   {24'h0, rx_a},   32'h0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      repeat (2) @(negedge clk);

      // loopback 0xA5
      start_frame(8'hA5, 8'hA5, 1'b1, e0);
      chk("ss_low_after_e0", {31'h0, ss_a}, 32'h0);
      chk("busy_after_e0",   {31'h0, busy_a}, 32'h1);
      wait_end(e0, "busy_fall_a5");
      chk("mosi_serial_a5", {24'h0, mosi_cap}, 32'hA5);
      chk("mosi_idle", {31'h0, mosi_a}, 32'h0);

      // slave model: 0x81 then 0x7E, slave returns 0x3C
      use_slv = 1'b1;
      start_frame(8'h81, 8'h3C, 1'b1, e0);
      wait_end(e0, "busy_fall_81");
      chk("slave_idata_81", {24'h0, s_idata}, 32'h81);
      start_frame(8'h7E, 8'h3C, 1'b1, e0);
      wait_end(e0, "busy_fall_7e");
      chk("slave_idata_7e", {24'h0, s_idata}, 32'h7E);
      use_slv = 1'b0;

      // start pulsed mid-frame is ignored
      d0 = ndone_a;
      start_frame(8'h3C, 8'h3C, 1'b1, e0);
      repeat (9) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_end(e0, "busy_fall_ignored");
      repeat (10) @(negedge clk);
      chk("single_done", ndone_a - d0, 1);
      chk("no_restart", {31'h0, busy_a}, 32'h0);

      // asynchronous reset mid-frame
      start_frame(8'h5A, 8'h00, 1'b0, e0);
      while (cyc < e0 + 30) @(negedge clk);
      rst_n_a = 1'b0;
      #1;
      chk("abort_ss",   {31'h0, ss_a},   32'h1);
      chk("abort_sclk", {31'h0, sclk_a}, 32'h0);
      chk("abort_busy", {31'h0, busy_a}, 32'h0);
      chk("abort_rx",   {24'h0, rx_a},   32'h0);
      repeat (3) @(negedge clk);
      rst_n_a = 1'b1;
      repeat (2) @(negedge clk);
      start_frame(8'hFF, 8'hFF, 1'b1, e0);
      wait_end(e0, "busy_fall_ff");

      // back-to-back 16-bit frames, T=2
      @(negedge clk);
      start_b = 1'b1;
      repeat (272) @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy_b) break;
      end
      chk("busy_b_end", {31'h0, busy_b}, 32'h0);
      chk("ndone_b", ndone_b, 4);

      chk("sb_a_empty", qa.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
